volume_ramp: RTL and testbench

Parametrised multi-channel volume stage for the audio path, successor to `volume`. It applies a per-sample arithmetic right-shift attenuation to `channels_p` signed PCM channels. Attenuation follows button presses via a smoothed ramp, one step per `ramp_samples_p` accepted samples, to avoid zipper noise. It adds mute and a valid/ready stream interface, and sits between the sample source and the DAC serializer.

---
 rtl/volume_pkg.sv | 25 ++
 rtl/edge_detect.sv | 22 ++
 rtl/volume_ramp.sv | 139 +++++++++++++
 tb/tb_volume_ramp.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/volume_pkg.sv
// Shared types and helpers for the ramped volume stage.
package volume_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } vol_cmd_e;

  function automatic int atten_width(input int max_v);
    return $clog2(max_v + 1);
  endfunction

  // Simultaneous up and down edges cancel out.
  function automatic vol_cmd_e decode_cmd(input logic up_edge, input logic down_edge);
    if (up_edge && !down_edge) begin
      return UP;
    end else if (down_edge && !up_edge) begin
      return DOWN;
    end else begin
      return NONE;
    end
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector on a level button; the previous level is registered
// and clears to 0, so a button held through reset yields one edge afterwards.
module edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic level_i,
  output logic edge_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_i;
    end
  end

  assign edge_o = level_i & ~prev_q;

endmodule

// File: rtl/volume_ramp.sv
// Multi-channel shift-attenuation volume stage with a sample-counted ramp
// toward the button-selected target, mute, and a one-register output stream.
module volume_ramp
  import volume_pkg::*;
#(
  parameter int width_p        = 24,
  parameter int channels_p     = 2,
  parameter int max_atten_p    = 7,
  parameter int reset_atten_p  = 1,
  parameter int ramp_samples_p = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   up_i,
  input  logic                                   down_i,
  input  logic                                   mute_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  input  logic [channels_p*width_p-1:0]          data_i,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic [channels_p*width_p-1:0]          data_o,
  output logic [atten_width(max_atten_p)-1:0]    atten_o,
  output logic                                   muted_o
);

  localparam int AW = atten_width(max_atten_p);
  localparam int CW = (ramp_samples_p > 1) ? $clog2(ramp_samples_p) : 1;
  localparam int DW = channels_p * width_p;
  localparam logic [AW-1:0] MAX_ATTEN   = AW'(max_atten_p);
  localparam logic [AW-1:0] RESET_ATTEN = AW'(reset_atten_p);
  localparam logic [CW-1:0] LAST_CNT    = CW'(ramp_samples_p - 1);

  logic           up_edge, down_edge, mute_edge;
  vol_cmd_e       cmd;
  logic           accept;

  logic [AW-1:0]  tgt_q, tgt_d;
  logic [AW-1:0]  cur_q, cur_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           muted_q, muted_d;
  logic           valid_q, valid_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  shifted;

  edge_detect u_up_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .level_i (up_i),
    .edge_o  (up_edge)
  );

  edge_detect u_down_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .level_i (down_i),
    .edge_o  (down_edge)
  );

  edge_detect u_mute_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .level_i (mute_i),
    .edge_o  (mute_edge)
  );

  assign cmd     = decode_cmd(up_edge, down_edge);
  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;

  generate
    for (genvar gi = 0; gi < channels_p; gi++) begin : g_chan
      logic signed [width_p-1:0] sample;
      assign sample = data_i[gi*width_p +: width_p];
      assign shifted[gi*width_p +: width_p] = sample >>> cur_q;
    end
  endgenerate

  always_comb begin
    tgt_d = tgt_q;
    case (cmd)
      UP:      if (tgt_q != '0) tgt_d = tgt_q - AW'(1);
      DOWN:    if (tgt_q != MAX_ATTEN) tgt_d = tgt_q + AW'(1);
      default: tgt_d = tgt_q;
    endcase
  end

  // Ramp progress only advances on accepted beats, so backpressure freezes it.
  always_comb begin
    cur_d = cur_q;
    cnt_d = cnt_q;
    if (cur_q == tgt_q) begin
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        cur_d = (tgt_q > cur_q) ? cur_q + AW'(1) : cur_q - AW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    muted_d = muted_q ^ mute_edge;
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = muted_q ? '0 : shifted;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tgt_q   <= RESET_ATTEN;
      cur_q   <= RESET_ATTEN;
      cnt_q   <= '0;
      muted_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      muted_q <= muted_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign atten_o = cur_q;
  assign muted_o = muted_q;

endmodule

// File: tb/tb_volume_ramp.sv
// Directed bench for volume_ramp with a queue scoreboard of expected output beats.
module tb_volume_ramp;

  localparam int W    = 24;
  localparam int C    = 2;
  localparam int DW   = W * C;
  localparam int MAXA = 7;
  localparam int RA   = 1;
  localparam int RS   = 4;

  logic          clk = 1'b0;
  logic          reset_i, up_i, down_i, mute_i, valid_i, ready_i;
  logic          ready_o, valid_o, muted_o;
  logic [DW-1:0] data_i, data_o;
  logic [2:0]    atten_o;

  always #5 clk = ~clk;

  volume_ramp dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .up_i    (up_i),
    .down_i  (down_i),
    .mute_i  (mute_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .atten_o (atten_o),
    .muted_o (muted_o)
  );

  int  total = 0;
  int  bad   = 0;
  int  m_cur = RA, m_tgt = RA, m_cnt = 0;
  bit  m_muted = 1'b0, m_valid = 1'b0;
  bit  m_pu = 1'b0, m_pd = 1'b0, m_pm = 1'b0;
  logic [DW-1:0] sb[$];

  function automatic logic [DW-1:0] expect_beat(input logic [DW-1:0] d, input int sh, input bit mute);
    logic [DW-1:0] r;
    logic signed [W-1:0] s;
    r = '0;
    if (!mute) begin
      for (int c = 0; c < C; c++) begin
        s = d[c*W +: W];
        r[c*W +: W] = s >>> sh;
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check pre-edge outputs, advance the reference model, check post-edge state.
  task automatic cycle();
    bit acc, up_e, dn_e, mu_e;
    logic [DW-1:0] exp_d;
    #1;
    if (!reset_i) begin
      chk("ready_o", 64'(ready_o), 64'(!m_valid || ready_i));
      if (m_valid && ready_i) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'(1));
        end else begin
          exp_d = sb.pop_front();
          chk("data_o", 64'(data_o), 64'(exp_d));
          $display("beat out data=%h atten=%0d muted=%0d", data_o, atten_o, muted_o);
        end
      end
    end
    if (reset_i) begin
      m_cur = RA; m_tgt = RA; m_cnt = 0; m_muted = 0; m_valid = 0;
      m_pu = 0; m_pd = 0; m_pm = 0;
      sb.delete();
    end else begin
      acc  = valid_i && (!m_valid || ready_i);
      up_e = up_i && !m_pu;
      dn_e = down_i && !m_pd;
      mu_e = mute_i && !m_pm;
      if (acc) sb.push_back(expect_beat(data_i, m_cur, m_muted));
      if (m_cur == m_tgt) begin
        m_cnt = 0;
      end else if (acc) begin
        if (m_cnt == RS - 1) begin
          m_cnt = 0;
          m_cur = (m_tgt > m_cur) ? m_cur + 1 : m_cur - 1;
        end else begin
          m_cnt++;
        end
      end
      if (up_e && !dn_e && m_tgt > 0) m_tgt--;
      if (dn_e && !up_e && m_tgt < MAXA) m_tgt++;
      if (mu_e) m_muted = !m_muted;
      if (acc) m_valid = 1;
      else if (ready_i) m_valid = 0;
      m_pu = up_i; m_pd = down_i; m_pm = mute_i;
    end
    @(posedge clk);
    #1;
    chk("atten_o", 64'(atten_o), 64'(m_cur));
    chk("muted_o", 64'(muted_o), 64'(m_muted));
    chk("valid_o", 64'(valid_o), 64'(m_valid));
  endtask

  task automatic beat(input logic [DW-1:0] d);
    valid_i = 1'b1;
    data_i  = d;
    cycle();
  endtask

  task automatic press_down();
    down_i = 1'b1; cycle();
    down_i = 1'b0; cycle();
  endtask

  task automatic press_up();
    up_i = 1'b1; cycle();
    up_i = 1'b0; cycle();
  endtask

  task automatic do_reset();
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    cycle();
    reset_i = 1'b0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] hold, d;
    logic [2:0] a_hold;
    reset_i = 1'b1; up_i = 0; down_i = 0; mute_i = 0;
    valid_i = 0; ready_i = 1; data_i = '0;
    cycle();
    cycle();
    reset_i = 1'b0;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_data", 64'(data_o), 64'(0));
    chk("rst_atten", 64'(atten_o), 64'(1));
    chk("rst_muted", 64'(muted_o), 64'(0));
    chk("rst_ready", 64'(ready_o), 64'(1));

    // Default attenuation of one shift.
    beat({24'hF00000, 24'h100000});
    chk("first_beat", 64'(data_o), 64'(48'hF80000_080000));

    // Ten down presses saturate the target at 7; ramp takes 24 beats.
    valid_i = 1'b0;
    repeat (10) press_down();
    n = 0;
    while (atten_o !== 3'd7 && n < 40) begin
      beat(rnd());
      n++;
    end
    chk("ramp_beats", 64'(n), 64'(24));
    beat(48'h000000_7FFFFF);
    chk("max_atten_data", 64'(data_o[23:0]), 64'(24'h00FFFF));

    // Ramp up with backpressure mid-ramp; a down press lands during the stall.
    valid_i = 1'b0;
    repeat (3) press_up();
    beat(rnd());
    beat(rnd());
    ready_i = 1'b0;
    hold   = data_o;
    a_hold = atten_o;
    for (int i = 0; i < 5; i++) begin
      down_i = (i == 1);
      beat(rnd());
      chk("bp_ready", 64'(ready_o), 64'(0));
      chk("bp_data_hold", 64'(data_o), 64'(hold));
      chk("bp_atten_hold", 64'(atten_o), 64'(a_hold));
    end
    down_i  = 1'b0;
    ready_i = 1'b1;
    n = 0;
    while (atten_o !== 3'd5 && n < 30) begin
      beat(rnd());
      n++;
    end
    chk("bp_ramp_done", 64'(atten_o), 64'(5));

    // Mute while the ramp keeps moving.
    mute_i = 1'b1; beat(rnd());
    mute_i = 1'b0;
    chk("mute_on", 64'(muted_o), 64'(1));
    down_i = 1'b1; beat(rnd());
    down_i = 1'b0; beat(rnd());
    down_i = 1'b1; beat(rnd());
    down_i = 1'b0;
    n = 0;
    while (atten_o !== 3'd7 && n < 30) begin
      beat(rnd());
      n++;
    end
    chk("muted_ramp", 64'(atten_o), 64'(7));
    beat(rnd());
    chk("muted_zero", 64'(data_o), 64'(0));
    mute_i = 1'b1; beat(rnd());
    mute_i = 1'b0;
    chk("mute_off", 64'(muted_o), 64'(0));
    d = 48'h123456_FEDCBA;
    beat(d);
    chk("unmuted_data", 64'(data_o), 64'(expect_beat(d, 7, 1'b0)));

    // Simultaneous up and down edges cancel.
    up_i = 1'b1; down_i = 1'b1; beat(rnd());
    up_i = 1'b0; down_i = 1'b0;
    repeat (8) beat(rnd());
    chk("updown_cancel", 64'(atten_o), 64'(7));

    // From reset, two ups saturate at 0 and the stage becomes transparent.
    do_reset();
    press_up();
    press_up();
    n = 0;
    while (atten_o !== 3'd0 && n < 20) begin
      beat(rnd());
      n++;
    end
    chk("up_beats", 64'(n), 64'(4));
    d = 48'h89ABCD_765432;
    beat(d);
    chk("unity_data", 64'(data_o), 64'(d));

    // Reset mid-ramp while muted and stalled.
    do_reset();
    repeat (6) press_down();
    mute_i = 1'b1; cycle();
    mute_i = 1'b0;
    repeat (12) beat(rnd());
    chk("pre_reset_atten", 64'(atten_o), 64'(4));
    ready_i = 1'b0;
    valid_i = 1'b0;
    cycle();
    chk("pre_reset_valid", 64'(valid_o), 64'(1));
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    chk("post_reset_atten", 64'(atten_o), 64'(1));
    chk("post_reset_valid", 64'(valid_o), 64'(0));
    chk("post_reset_muted", 64'(muted_o), 64'(0));

    ready_i = 1'b1;
    valid_i = 1'b0;
    repeat (2) cycle();
    chk("sb_drain", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
